iob_modcnt_mc: RTL
==================

// Module: iob_modcnt_mc
// PURPOSE
//  Multi-channel modulo counter; successor to the single-channel modulo counter.
//  N_CH independent counters, each with its own modulus, explicit load and up/down direction.
//  Each channel outputs a registered wrap pulse.
//  Optional cascade mode chains channels into one mixed-radix counter (prescalers, timebases, baud/tick generators).
// PARAMETERS
//  DATA_W   32  counter/modulus width per channel
//  N_CH     4   number of channels (>=1)
//  CASCADE  0   0: channels independent; 1: ch i>0 steps only on carry out of ch i-1
// PORTS
//  clk       in   1            clock, rising edge
//  arst_n    in   1            asynchronous reset, active-low
//  rst       in   1            synchronous clear, all channels
//  en        in   N_CH         per-channel step enable
//  load      in   N_CH         per-channel load strobe
//  load_val  in   N_CH*DATA_W  load values, ch i at [i*DATA_W +: DATA_W]
//  mod       in   N_CH*DATA_W  moduli, same packing; 0 means 2^DATA_W
//  dir       in   N_CH         0: count up, 1: count down
//  cnt       out  N_CH*DATA_W  counter values, same packing
//  wrap      out  N_CH         registered one-cycle wrap pulse per channel
// BEHAVIOUR
//  Reset
//   - arst_n=0: all cnt=0, wrap=0, immediately.
//   - rst=1 at clock edge: same values; overrides load and en.
//  Per-channel step
//   - Priority: arst_n > rst > load[i] > step_i.
//   - CASCADE=0: step_i = en[i].
//   - CASCADE=1: step_0 = en[0]; step_i = en[i] & carry_{i-1}.
//  Terminal and carry
//   - term_i (up) = cnt_i >= mod_i-1 (DATA_W-bit compare).
//   - term_i (down) = cnt_i == 0.
//   - carry_i = step_i & term_i & ~load[i]; combinational, same cycle, no added latency down the chain.
//  Up step (dir=0)
//   - term_i: cnt_i <= 0, wrap[i] <= 1.
//   - else: cnt_i <= cnt_i+1.
//   - Out-of-range cnt (>= mod) therefore wraps to 0 on its next step.
//  Down step (dir=1)
//   - cnt_i==0: cnt_i <= mod_i-1, wrap[i] <= 1.
//   - cnt_i >= mod_i (mod_i != 0): cnt_i <= mod_i-1, no wrap.
//   - else: cnt_i <= cnt_i-1.
//  Load
//   - load[i]: cnt_i <= load_val_i unchecked, no wrap, no carry, en[i] ignored.
//   - The next channel does not step from this channel in that cycle.
//  Wrap output
//   - wrap[i] is 1 only in the cycle after a wrapping step, coincident with the wrapped cnt value.
//   - Otherwise wrap[i] is 0.
//  mod_i=0
//   - Full 2^DATA_W range: up wraps from all-ones to 0; down wraps from 0 to all-ones.
//  mod_i=1
//   - cnt stays 0 and wraps on every step.
//  Timing
//   - Latency: cnt updates 1 cycle after the step/load edge.
//   - dir and mod may change any cycle; they take effect on the next step.
//  Simultaneous events
//   - rst with load: rst wins.
//   - load with en: load wins.
//   - Cascade: a loaded upstream channel blocks its downstream step that cycle.
// TESTING
//  T1 N_CH=1, mod=5, dir=0, en=1 for 6 cycles from reset -> cnt 1,2,3,4,0,1; wrap=1 only with the first 0.
//  T2 load_val=1, load 1 cycle; then dir=1, mod=3, en for 4 cycles -> cnt 1,0,2,1,0; wrap with 2.
//  T3 CASCADE=1, N_CH=2, mod=10/10, en=2'b11 for 100 cycles -> cnt={0,0}; wrap[1] once; wrap[0] 10 times.
//  T4 mod=0, load all-ones, en 1 cycle, up -> cnt=0, wrap=1; down from 0 -> all-ones, wrap=1.
//  T5 load=1 with en=1, load_val=7, mod=5 -> cnt=7, no wrap; next up step -> cnt=0, wrap=1.
//  T6 arst_n low mid-count -> cnt=0, wrap=0 before the next edge; rst=1 with load=1 -> cnt=0.

Source files
------------

// File: rtl/iob_modcnt_mc.sv
// ----------------------------------------------------------------------------
// iob_modcnt_mc
// Multi-channel modulo counter. Each of N_CH channels counts up or down
// modulo its own modulus (0 selects the full 2^DATA_W range), can be loaded
// with an arbitrary value, and emits a registered one-cycle wrap pulse.
// With CASCADE=1 the channels form one mixed-radix counter: channel i>0
// only steps in a cycle where channel i-1 produces a carry.
// ----------------------------------------------------------------------------
module iob_modcnt_mc #(
  parameter int DATA_W  = 32,
  parameter int N_CH    = 4,
  parameter int CASCADE = 0
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     rst,
  input  logic [N_CH-1:0]          en,
  input  logic [N_CH-1:0]          load,
  input  logic [N_CH*DATA_W-1:0]   load_val,
  input  logic [N_CH*DATA_W-1:0]   mod,
  input  logic [N_CH-1:0]          dir,
  output logic [N_CH*DATA_W-1:0]   cnt,
  output logic [N_CH-1:0]          wrap
);

  localparam logic [DATA_W-1:0] cnt_one = DATA_W'(1);

  logic [N_CH*DATA_W-1:0] cnt_nxt;
  logic [N_CH-1:0]        wrap_nxt;

  // Next-state for every channel, with the carry rippling down the chain in
  // the same cycle so a cascaded counter adds no latency per stage.
  always_comb begin
    logic              chain_in;
    logic              step_i;
    logic              term_i;
    logic              carry_i;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] mod_i;
    logic [DATA_W-1:0] mod_m1;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips it would infer a latch.
    cnt_nxt  = cnt;
    wrap_nxt = '0;
    chain_in = 1'b1;
    step_i   = 1'b0;
    term_i   = 1'b0;
    carry_i  = 1'b0;
    cur      = '0;
    mod_i    = '0;
    mod_m1   = '0;
    for (int i = 0; i < N_CH; i++) begin
      cur     = cnt[i*DATA_W +: DATA_W];
      mod_i   = mod[i*DATA_W +: DATA_W];
      // mod=0 becomes all-ones here, which gives the full 2^DATA_W range.
      mod_m1  = mod_i - cnt_one;
      step_i  = en[i] & chain_in;
      term_i  = dir[i] ? (cur == '0) : (cur >= mod_m1);
      carry_i = 1'b0;
      if (load[i]) begin
        // Load is unchecked and produces neither wrap nor carry.
        cnt_nxt[i*DATA_W +: DATA_W] = load_val[i*DATA_W +: DATA_W];
      end else if (step_i) begin
        carry_i     = term_i;
        wrap_nxt[i] = term_i;
        if (!dir[i]) begin
          cnt_nxt[i*DATA_W +: DATA_W] = term_i ? '0 : cur + cnt_one;
        end else if (term_i) begin
          cnt_nxt[i*DATA_W +: DATA_W] = mod_m1;
        end else if ((mod_i != '0) && (cur >= mod_i)) begin
          // Out-of-range value re-enters at the top without a wrap.
          cnt_nxt[i*DATA_W +: DATA_W] = mod_m1;
        end else begin
          cnt_nxt[i*DATA_W +: DATA_W] = cur - cnt_one;
        end
      end
      chain_in = (CASCADE != 0) ? carry_i : 1'b1;
    end
  end

  // Counter and wrap registers; synchronous clear overrides load and step.
  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!arst_n) begin
      cnt  <= '0;
      wrap <= '0;
    end else if (rst) begin
      cnt  <= '0;
      wrap <= '0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule
